// File: rtl/tensor_pe_dot_if.sv
// Bundle of the operation-issue and writeback handshakes for tensor_pe_dot.
// valid/ready: a transfer happens on a rising clock edge where both are high; the sender
// holds its payload stable and keeps valid high until that edge.
interface tensor_pe_dot_if #(
  parameter int XLEN      = 32,
  parameter int NUM_WARPS = 4,
  parameter int NUM_TILES = 2,
  parameter int NUM_STEPS = 4
);
  localparam int WIDW  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int TILEW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int STEPW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [XLEN-1:0]  in_c;
  logic [1:0]       in_acc_src;
  logic             in_mode;
  logic             in_wb;
  logic [WIDW-1:0]  in_wid;
  logic [TILEW-1:0] in_tile;
  logic [STEPW-1:0] in_step;
  logic [4:0]       in_rd;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [WIDW-1:0]  out_wid;
  logic [4:0]       out_rd;

  modport master (
    output in_valid, in_a, in_b, in_c, in_acc_src, in_mode, in_wb,
           in_wid, in_tile, in_step, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_wid, out_rd
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_acc_src, in_mode, in_wb,
           in_wid, in_tile, in_step, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_wid, out_rd
  );
endinterface

// File: rtl/tensor_pe_dot.sv
// Packed INT16/INT8 dot-product PE with a per-warp accumulator tile buffer.
// Products are summed at accept, the accumulator is added at the last stage.
module tensor_pe_dot #(
  parameter int XLEN       = 32,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_TILES  = 2,
  parameter int NUM_STEPS  = 4,
  parameter int PIPE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  tensor_pe_dot_if.slave  bus
);
  localparam int WIDW  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int TILEW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int STEPW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int LAST  = PIPE_DEPTH - 1;

  localparam logic [1:0] ACC_REG  = 2'd1;
  localparam logic [1:0] ACC_TILE = 2'd2;

  logic             r_vld  [PIPE_DEPTH];
  logic             r_wb   [PIPE_DEPTH];
  logic [XLEN-1:0]  r_dot  [PIPE_DEPTH];
  logic [XLEN-1:0]  r_acc  [PIPE_DEPTH];
  logic [WIDW-1:0]  r_wid  [PIPE_DEPTH];
  logic [TILEW-1:0] r_tsel [PIPE_DEPTH];
  logic [STEPW-1:0] r_step [PIPE_DEPTH];
  logic [4:0]       r_rd   [PIPE_DEPTH];

  logic [XLEN-1:0]  r_mem [NUM_WARPS][NUM_TILES][NUM_STEPS];
  logic             r_run;

  logic [XLEN-1:0]  w_dot;
  logic [XLEN-1:0]  w_acc;
  logic [XLEN-1:0]  w_result;
  logic             w_stall;
  logic             w_hazard;
  logic             w_accept;
  logic             w_tile_wr;

  // Sign-extend each element to XLEN first so the running sum wraps mod 2^XLEN.
  always_comb begin
    w_dot = '0;
    if (bus.in_mode) begin
      for (int j = 0; j < XLEN / 8; j++) begin
        w_dot = w_dot + XLEN'($signed(bus.in_a[j*8 +: 8])) * XLEN'($signed(bus.in_b[j*8 +: 8]));
      end
    end else begin
      for (int j = 0; j < XLEN / 16; j++) begin
        w_dot = w_dot + XLEN'($signed(bus.in_a[j*16 +: 16])) * XLEN'($signed(bus.in_b[j*16 +: 16]));
      end
    end
  end

  always_comb begin
    w_acc = '0;
    case (bus.in_acc_src)
      ACC_REG:  w_acc = bus.in_c;
      ACC_TILE: w_acc = r_mem[bus.in_wid][bus.in_tile][bus.in_step];
      default:  w_acc = '0;
    endcase
  end

  // A TILE read must not overtake a pending write to the same entry anywhere in flight.
  always_comb begin
    w_hazard = 1'b0;
    if (bus.in_acc_src == ACC_TILE) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (r_vld[i] && !r_wb[i] && r_wid[i] == bus.in_wid &&
            r_tsel[i] == bus.in_tile && r_step[i] == bus.in_step) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  assign w_stall   = r_vld[LAST] && r_wb[LAST] && !bus.out_ready;
  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_result  = r_dot[LAST] + r_acc[LAST];
  assign w_tile_wr = r_vld[LAST] && !r_wb[LAST];

  assign bus.in_ready  = r_run && !w_stall && !w_hazard;
  assign bus.out_valid = r_vld[LAST] && r_wb[LAST];
  assign bus.out_data  = w_result;
  assign bus.out_wid   = r_wid[LAST];
  assign bus.out_rd    = r_rd[LAST];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_wb[i]   <= 1'b0;
        r_dot[i]  <= '0;
        r_acc[i]  <= '0;
        r_wid[i]  <= '0;
        r_tsel[i] <= '0;
        r_step[i] <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      r_run <= 1'b1;
      if (!w_stall) begin
        r_vld[0] <= w_accept;
        if (w_accept) begin
          r_wb[0]   <= bus.in_wb;
          r_dot[0]  <= w_dot;
          r_acc[0]  <= w_acc;
          r_wid[0]  <= bus.in_wid;
          r_tsel[0] <= bus.in_tile;
          r_step[0] <= bus.in_step;
          r_rd[0]   <= bus.in_rd;
        end
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          r_vld[i]  <= r_vld[i-1];
          r_wb[i]   <= r_wb[i-1];
          r_dot[i]  <= r_dot[i-1];
          r_acc[i]  <= r_acc[i-1];
          r_wid[i]  <= r_wid[i-1];
          r_tsel[i] <= r_tsel[i-1];
          r_step[i] <= r_step[i-1];
          r_rd[i]   <= r_rd[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int t = 0; t < NUM_TILES; t++) begin
          for (int s = 0; s < NUM_STEPS; s++) begin
            r_mem[w][t][s] <= '0;
          end
        end
      end
    end else if (w_tile_wr) begin
      r_mem[r_wid[LAST]][r_tsel[LAST]][r_step[LAST]] <= w_result;
    end
  end

  a_index_range: assert property (@(posedge clk) disable iff (!reset_n)
    w_accept |-> (32'(bus.in_wid) < NUM_WARPS) && (32'(bus.in_tile) < NUM_TILES) &&
                 (32'(bus.in_step) < NUM_STEPS));
endmodule

// File: tb/tb_tensor_pe_dot.sv
// Directed bench for tensor_pe_dot: hand-computed vectors, writeback scoreboard,
// tile hazards, backpressure and mid-operation reset.
module tb_tensor_pe_dot;
  localparam int XLEN = 32;
  localparam int NW   = 4;
  localparam int NT   = 2;
  localparam int NS   = 4;
  localparam int PD   = 2;

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_REG  = 2'd1;
  localparam logic [1:0] SRC_TILE = 2'd2;

  logic clk = 1'b0;
  logic reset_n;

  int n_checks = 0;
  int n_fail   = 0;
  int st;

  // {wid, rd, data}
  logic [38:0] exp_q[$];

  always #5 clk = ~clk;

  tensor_pe_dot_if #(.XLEN(XLEN), .NUM_WARPS(NW), .NUM_TILES(NT), .NUM_STEPS(NS)) bus ();

  tensor_pe_dot #(
    .XLEN(XLEN), .NUM_WARPS(NW), .NUM_TILES(NT), .NUM_STEPS(NS), .PIPE_DEPTH(PD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drives right after a posedge so negedge samples hold for the next edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [1:0] src, input logic mode, input logic wb,
                       input logic [1:0] wid, input logic tile, input logic [1:0] step,
                       input logic [4:0] rd, input logic [31:0] expv, input logic track,
                       output int stalls);
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_c       = c;
    bus.in_acc_src = src;
    bus.in_mode    = mode;
    bus.in_wb      = wb;
    bus.in_wid     = wid;
    bus.in_tile    = tile;
    bus.in_step    = step;
    bus.in_rd      = rd;
    bus.in_valid   = 1'b1;
    if (wb && track) exp_q.push_back({wid, rd, expv});
    stalls = 0;
    @(negedge clk);
    while (!bus.in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_eq("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    sync();
    bus.in_valid = 1'b0;
  endtask

  task automatic readout(input logic [1:0] wid, input logic tile, input logic [1:0] step,
                         input logic [4:0] rd, input logic [31:0] expv);
    int s;
    issue(32'd0, 32'd0, 32'd0, SRC_TILE, 1'b0, 1'b1, wid, tile, step, rd, expv, 1'b1, s);
  endtask

  always @(negedge clk) begin
    logic [38:0] e;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", {32'd0, bus.out_data}, {32'd0, e[31:0]});
        check_eq("out_rd", {59'd0, bus.out_rd}, {59'd0, e[36:32]});
        check_eq("out_wid", {62'd0, bus.out_wid}, {62'd0, e[38:37]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_c       = '0;
    bus.in_acc_src = '0;
    bus.in_mode    = 1'b0;
    bus.in_wb      = 1'b0;
    bus.in_wid     = '0;
    bus.in_tile    = '0;
    bus.in_step    = '0;
    bus.in_rd      = '0;
    bus.out_ready  = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    check_eq("rst_out_wid", {62'd0, bus.out_wid}, 64'd0);
    check_eq("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);
    check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    sync();
    reset_n = 1'b1;

    // INT16, REG accumulator: -2*5 + 3*4 + 10 = 12, visible two cycles after accept
    issue(32'h0003_FFFE, 32'h0004_0005, 32'd10, SRC_REG, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0,
          5'd7, 32'd12, 1'b1, st);
    @(negedge clk);
    check_eq("t1_lat_early", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    check_eq("t1_lat_due", {63'd0, bus.out_valid}, 64'd1);
    sync();

    // INT8 modes, issued back-to-back
    issue(32'h0102_0304, 32'h0101_0101, 32'd0, SRC_ZERO, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0,
          5'd1, 32'd10, 1'b1, st);
    issue(32'hFF00_0000, 32'h0200_0000, 32'd0, SRC_ZERO, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0,
          5'd2, 32'hFFFF_FFFE, 1'b1, st);
    check_eq("t2_b2b_stalls", 64'(st), 64'd0);

    // Dependent tile accumulate on warp 1, tile 1, step 2
    issue(32'h0102_0304, 32'h0101_0101, 32'd0, SRC_ZERO, 1'b1, 1'b0, 2'd1, 1'b1, 2'd2,
          5'd0, 32'd10, 1'b1, st);
    issue(32'h0102_0304, 32'h0101_0101, 32'd0, SRC_TILE, 1'b1, 1'b0, 2'd1, 1'b1, 2'd2,
          5'd0, 32'd20, 1'b1, st);
    check_eq("t3_dep_stalls", 64'(st), 64'd2);
    readout(2'd1, 1'b1, 2'd2, 5'd9, 32'd20);

    // Writes to different entries back-to-back need no stall
    issue(32'd7, 32'd1, 32'd0, SRC_ZERO, 1'b0, 1'b0, 2'd2, 1'b0, 2'd3, 5'd0, 32'd7, 1'b1, st);
    issue(32'd3, 32'd1, 32'd0, SRC_ZERO, 1'b0, 1'b0, 2'd2, 1'b0, 2'd1, 5'd0, 32'd3, 1'b1, st);
    check_eq("t3_diff_entry_stalls", 64'(st), 64'd0);
    readout(2'd2, 1'b0, 2'd3, 5'd10, 32'd7);
    readout(2'd2, 1'b0, 2'd1, 5'd14, 32'd3);

    // Clear idiom, then read the cleared entry back
    issue(32'd0, 32'd0, 32'd0, SRC_ZERO, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2, 5'd0, 32'd0, 1'b1, st);
    readout(2'd1, 1'b1, 2'd2, 5'd15, 32'd0);
    repeat (3) sync();

    // Backpressure: A=23+100, B=-128, C=2
    bus.out_ready = 1'b0;
    issue(32'h0002_0003, 32'h0004_0005, 32'd100, SRC_REG, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0,
          5'd11, 32'd123, 1'b1, st);
    issue(32'h8000_0000, 32'h0100_0000, 32'd0, SRC_ZERO, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0,
          5'd12, 32'hFFFF_FF80, 1'b1, st);
    bus.in_a       = 32'h0001_0001;
    bus.in_b       = 32'h0001_0001;
    bus.in_c       = 32'd0;
    bus.in_acc_src = SRC_ZERO;
    bus.in_mode    = 1'b0;
    bus.in_wb      = 1'b1;
    bus.in_wid     = 2'd2;
    bus.in_tile    = 1'b0;
    bus.in_step    = 2'd0;
    bus.in_rd      = 5'd13;
    bus.in_valid   = 1'b1;
    exp_q.push_back({2'd2, 5'd13, 32'd2});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t4_full_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check_eq("t4_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check_eq("t4_hold_data", {32'd0, bus.out_data}, 64'd123);
      sync();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_accept_on_release", {63'd0, bus.in_ready}, 64'd1);
    sync();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_second_out", {63'd0, bus.out_valid}, 64'd1);
    @(negedge clk);
    check_eq("t4_third_out", {63'd0, bus.out_valid}, 64'd1);
    sync();

    // Wrap: 0x7FFFFFFF + 1
    issue(32'd1, 32'd1, 32'h7FFF_FFFF, SRC_REG, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0,
          5'd20, 32'h8000_0000, 1'b1, st);

    // Reset mid-operation
    issue(32'd5, 32'd1, 32'd0, SRC_ZERO, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 32'd5, 1'b1, st);
    readout(2'd0, 1'b0, 2'd0, 5'd4, 32'd5);
    repeat (3) sync();
    issue(32'd7, 32'd1, 32'd0, SRC_ZERO, 1'b0, 1'b0, 2'd3, 1'b1, 2'd3, 5'd0, 32'd7, 1'b1, st);
    issue(32'd0, 32'd0, 32'd1, SRC_REG, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 5'd21, 32'd1, 1'b0, st);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t6_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check_eq("t6_rst_out_data", {32'd0, bus.out_data}, 64'd0);
      check_eq("t6_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    sync();
    reset_n = 1'b1;
    readout(2'd0, 1'b0, 2'd0, 5'd5, 32'd0);
    readout(2'd3, 1'b1, 2'd3, 5'd6, 32'd0);

    repeat (4) @(negedge clk);
    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
